// File: rtl/clz_pkg.sv
// Shared types for the sequential count-leading/trailing-zeros unit.
package clz_pkg;

    // Operation encoding: bit 1 selects trailing-zero count, bit 0 selects the 32-bit form.
    typedef enum logic [1:0] {
        OP_CLZ  = 2'b00,
        OP_CLZW = 2'b01,
        OP_CTZ  = 2'b10,
        OP_CTZW = 2'b11
    } clz_op_t;

    // Control states of the chunk scanner.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } clz_state_t;

    // Value reported when every scanned bit is zero.
    localparam logic [6:0] ALL_ZERO_COUNT = 7'd64;

endpackage

// File: rtl/count_leading_zeros.sv
// Combinational leading-zero count of a 2**LG_N bit word; all-zero gives 2**LG_N.
module count_leading_zeros #(
    parameter int LG_N = 4
) (
    input  logic [(1<<LG_N)-1:0] data,
    output logic [LG_N:0]        count
);

    // Walk from LSB up so the highest set bit has the final word.
    always_comb begin
        count = (LG_N+1)'(1 << LG_N);
        for (int i = 0; i < (1 << LG_N); i++) begin
            if (data[i]) begin
                count = (LG_N+1)'((1 << LG_N) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/clz_seq_unit.sv
// Sequential CLZ/CLZW/CTZ/CTZW unit: scans one 16-bit chunk per cycle, MSB chunk first.
// Trailing counts are turned into leading counts by bit-reversing the operand at
// acceptance; word forms pad the low half with ones so the count saturates at 32.
module clz_seq_unit
    import clz_pkg::*;
#(
    parameter int TAG_W    = 6,
    parameter int CHUNK_LG = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [63:0]      in_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [TAG_W-1:0] out_tag
);

    clz_state_t       state_reg, state_next;
    logic [1:0]       k_reg, k_next;
    logic [63:0]      operand_reg, operand_next;
    logic [6:0]       result_reg, result_next;
    logic [TAG_W-1:0] tag_reg, tag_next;

    logic [63:0]       src_rev;
    logic [63:0]       src_prep;
    logic [15:0]       chunk;
    logic [CHUNK_LG:0] chunk_count;
    logic [6:0]        scan_count;
    logic              accept;

    // Full 64-bit reversal; its upper half is also the reversal of src[31:0].
    for (genvar gi = 0; gi < 64; gi++) begin : g_rev
        assign src_rev[gi] = in_src[63-gi];
    end

    // Operand as it will be scanned, chosen by the operation.
    always_comb begin
        src_prep = in_src;
        case (in_op)
            OP_CLZ:  src_prep = in_src;
            OP_CLZW: src_prep = {in_src[31:0], 32'hFFFF_FFFF};
            OP_CTZ:  src_prep = src_rev;
            OP_CTZW: src_prep = {src_rev[63:32], 32'hFFFF_FFFF};
            default: src_prep = in_src;
        endcase
    end

    // Select the chunk addressed by k, chunk 0 being bits 63:48.
    always_comb begin
        chunk = operand_reg[63:48];
        case (k_reg)
            2'd0:    chunk = operand_reg[63:48];
            2'd1:    chunk = operand_reg[47:32];
            2'd2:    chunk = operand_reg[31:16];
            default: chunk = operand_reg[15:0];
        endcase
    end

    count_leading_zeros #(
        .LG_N (CHUNK_LG)
    ) u_clz16 (
        .data  (chunk),
        .count (chunk_count)
    );

    // 16*k + clz16(chunk); only used when the chunk is non-zero, so the sum stays below 64.
    assign scan_count = {1'b0, k_reg, 4'b0000} + 7'(chunk_count);

    assign in_ready   = ~flush & ((state_reg == ST_IDLE) |
                                  ((state_reg == ST_DONE) & out_ready));
    assign accept     = in_valid & in_ready;
    assign out_valid  = (state_reg == ST_DONE);
    assign out_result = {57'd0, result_reg};
    assign out_tag    = tag_reg;

    // Next-state logic: load on accept, advance one chunk per SCAN cycle, hold result in DONE.
    always_comb begin
        state_next   = state_reg;
        k_next       = k_reg;
        operand_next = operand_reg;
        result_next  = result_reg;
        tag_next     = tag_reg;
        if (flush) begin
            state_next = ST_IDLE;
            k_next     = 2'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_next   = ST_SCAN;
                        k_next       = 2'd0;
                        operand_next = src_prep;
                        tag_next     = in_tag;
                    end
                end
                ST_SCAN: begin
                    if (|chunk) begin
                        result_next = scan_count;
                        state_next  = ST_DONE;
                    end else if (k_reg == 2'd3) begin
                        result_next = ALL_ZERO_COUNT;
                        state_next  = ST_DONE;
                    end else begin
                        k_next = k_reg + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        if (accept) begin
                            state_next   = ST_SCAN;
                            k_next       = 2'd0;
                            operand_next = src_prep;
                            tag_next     = in_tag;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    k_next     = 2'd0;
                end
            endcase
        end
    end

    // State register with asynchronous clear of control and visible outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            k_reg       <= 2'd0;
            operand_reg <= 64'd0;
            result_reg  <= 7'd0;
            tag_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            k_reg       <= k_next;
            operand_reg <= operand_next;
            result_reg  <= result_next;
            tag_reg     <= tag_next;
        end
    end

endmodule

// File: tb/tb_clz_seq_unit.sv
// Bench for clz_seq_unit: directed corner cases plus random traffic against a count model.
module tb_clz_seq_unit;

    localparam int TAG_W = 6;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op = 2'b00;
    logic [63:0]      in_src = 64'd0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [63:0]      out_result;
    logic [TAG_W-1:0] out_tag;

    clz_seq_unit #(.TAG_W(TAG_W), .CHUNK_LG(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src     (in_src),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference count straight from the operation definitions.
    function automatic int model_count(input logic [1:0] op, input logic [63:0] s);
        int  c;
        bit  hit;
        int  width;
        c = 0;
        hit = 0;
        width = op[0] ? 32 : 64;
        if (!op[1]) begin
            for (int i = width - 1; i >= 0; i--) begin
                if (!hit) begin
                    if (s[i]) hit = 1; else c++;
                end
            end
        end else begin
            for (int i = 0; i < width; i++) begin
                if (!hit) begin
                    if (s[i]) hit = 1; else c++;
                end
            end
        end
        return c;
    endfunction

    // Cycles from accept to out_valid: index of the first non-zero 16-bit chunk plus one.
    function automatic int model_latency(input int c);
        return (c >= 48) ? 4 : (c / 16) + 1;
    endfunction

    // Transaction-level model: at most one op held, visible after edge vis_edge.
    bit               have = 0;
    logic [6:0]       m_res = '0;
    logic [TAG_W-1:0] m_tag = '0;
    int               vis_edge = 0;
    int               edge_idx = 0;
    int               n_acc = 0;

    always @(posedge clk) begin
        bit done;
        bit exp_ready;
        int c;
        if (!reset_n) begin
            have = 0;
        end else begin
            done = have && (edge_idx > vis_edge);
            exp_ready = !flush && (!have || (done && out_ready));
            if (flush) begin
                have = 0;
            end else begin
                if (done && out_ready) have = 0;
                if (in_valid && exp_ready) begin
                    c = model_count(in_op, in_src);
                    have = 1;
                    m_res = 7'(c);
                    m_tag = in_tag;
                    vis_edge = edge_idx + model_latency(c);
                    n_acc++;
                end
            end
        end
        edge_idx++;
    end

    // Compare every cycle, sampled mid-period.
    always @(negedge clk) begin
        bit done;
        if (!reset_n) begin
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_out_result", out_result, 64'd0);
            check("rst_out_tag", 64'(out_tag), 64'd0);
        end else begin
            done = have && (edge_idx - 1 >= vis_edge);
            check("in_ready", 64'(in_ready), 64'(!flush && (!have || (done && out_ready))));
            check("out_valid", 64'(out_valid), 64'(done));
            if (done) begin
                check("out_result", out_result, 64'(m_res));
                check("out_tag", 64'(out_tag), 64'(m_tag));
            end
        end
    end

    // Single op from idle with out_ready high; checks latency, count and tag.
    task automatic run_op(input string name, input logic [1:0] op, input logic [63:0] src,
                          input logic [TAG_W-1:0] tag, input int exp_res, input int exp_lat);
        int n;
        in_op = op; in_src = src; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 8);
        check({name, "_latency"}, 64'(n), 64'(exp_lat));
        check({name, "_result"}, out_result, 64'(exp_res));
        check({name, "_tag"}, 64'(out_tag), 64'(tag));
        $display("op %s op=%0d src=%h tag=%0d -> result=%0d latency=%0d", name, op, src, tag, out_result, n);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        int target;
        int cyc;

        // Pin the model itself with hand-computed values.
        check("model_clz_msb", 64'(model_count(2'b00, 64'h8000_0000_0000_0000)), 64'd0);
        check("model_clz_zero", 64'(model_count(2'b00, 64'd0)), 64'd64);
        check("model_ctz_zero", 64'(model_count(2'b10, 64'd0)), 64'd64);
        check("model_clzw", 64'(model_count(2'b01, 64'hFFFF_FFFF_0000_0001)), 64'd31);
        check("model_ctzw", 64'(model_count(2'b11, 64'h1_0000_0000)), 64'd32);
        check("model_ctz_10", 64'(model_count(2'b10, 64'h10)), 64'd4);

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        #1 check("ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        run_op("clz_msb",   2'b00, 64'h8000_0000_0000_0000, 6'd1, 0, 1);
        run_op("clz_zero",  2'b00, 64'd0,                   6'd2, 64, 4);
        run_op("ctz_zero",  2'b10, 64'd0,                   6'd3, 64, 4);
        run_op("clzw",      2'b01, 64'hFFFF_FFFF_0000_0001, 6'd4, 31, 2);
        run_op("ctzw",      2'b11, 64'h1_0000_0000,         6'd5, 32, 3);
        run_op("ctz_10",    2'b10, 64'h10,                  6'd6, 4, 1);

        // Held result, then out handshake and new accept on the same edge.
        in_op = 2'b00; in_src = 64'h0000_0100_0000_0000; in_tag = 6'd5;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 8) begin @(posedge clk); #1; n++; end
        repeat (3) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_tag", 64'(out_tag), 64'd5);
            check("hold_result", out_result, 64'd23);
        end
        in_op = 2'b10; in_src = 64'h8000_0000_0000_0000; in_tag = 6'd6;
        in_valid = 1'b1; out_ready = 1'b1;
        #1 check("b2b_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_valid_dropped", 64'(out_valid), 64'd0);
        n = 0;
        while (!out_valid && n < 8) begin @(posedge clk); #1; n++; end
        check("b2b_second_tag", 64'(out_tag), 64'd6);
        check("b2b_second_result", out_result, 64'd63);
        $display("op b2b tags 5 then %0d result=%0d", out_tag, out_result);
        @(posedge clk); #1;

        // Flush while scanning chunk 2 of an all-zero operand.
        in_op = 2'b00; in_src = 64'd0; in_tag = 6'd9; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (6) begin
            check("flush_no_valid", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end
        run_op("after_flush", 2'b00, 64'h0000_0000_0000_0F00, 6'd11, 52, 4);

        // Reset pulse while scanning: outputs clear at once, op lost.
        in_op = 2'b00; in_src = 64'd0; in_tag = 6'd12; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_result", out_result, 64'd0);
        check("async_rst_tag", 64'(out_tag), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (6) begin
            check("post_rst_no_valid", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end

        // Random traffic.
        target = n_acc + 10000;
        cyc = 0;
        while (n_acc < target && cyc < 80000) begin
            in_valid  = ($urandom % 5) != 0;
            out_ready = ($urandom % 5) != 0;
            flush     = ($urandom % 64) == 0;
            in_op     = 2'($urandom);
            in_src    = {$urandom, $urandom} >> 7'($urandom_range(0, 64));
            in_tag    = TAG_W'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++;
        if (n_acc < target) begin
            n_bad++;
            $display("FAIL random_ops: accepted %0d required %0d within cycle budget", n_acc, target);
        end
        $display("random phase: %0d ops accepted in %0d cycles", n_acc, cyc);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
